// File: rtl/io_pad_power_seq.sv
// IO pad power sequencer: qualifies both supplies, then releases isolation,
// core reset and pad output-enable in order; any supply loss drops all three at once.
module io_pad_power_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RAMP_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic       ck,
  input  logic       nrst,
  input  logic       vdd_ok,
  input  logic       vddio_ok,
  input  logic       enable,
  output logic       iso,
  output logic       por_n,
  output logic       pad_oe_en,
  output logic [2:0] state,
  output logic [3:0] fault_cnt
);

  localparam int unsigned TIMER_W    = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned RST_STAGES = 2;

  localparam logic [TIMER_W-1:0] RAMP_LAST = TIMER_W'(RAMP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_RAMP   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_OEWAIT = 3'd3,
    ST_ON     = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  logic [RST_STAGES-1:0]  rst_sync_q, rst_sync_d;
  logic [SYNC_STAGES-1:0] vdd_sync_q, vdd_sync_d;
  logic [SYNC_STAGES-1:0] vddio_sync_q, vddio_sync_d;
  state_e                 state_q, state_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [CNT_W-1:0]       fault_cnt_q, fault_cnt_d;
  logic                   iso_q, iso_d;
  logic                   por_n_q, por_n_d;
  logic                   pad_oe_en_q, pad_oe_en_d;

  logic rst_done;
  logic sup_ok;
  logic fault_evt;

  // Synchronizer shift paths; the reset synchronizer shifts in a constant 1.
  always_comb begin
    rst_sync_d   = {rst_sync_q[RST_STAGES-2:0], 1'b1};
    vdd_sync_d   = {vdd_sync_q[SYNC_STAGES-2:0], vdd_ok};
    vddio_sync_d = {vddio_sync_q[SYNC_STAGES-2:0], vddio_ok};
  end

  assign rst_done = rst_sync_q[RST_STAGES-1];
  assign sup_ok   = vdd_sync_q[SYNC_STAGES-1] & vddio_sync_q[SYNC_STAGES-1];

  // Next-state, timer, fault counter and output decode.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    fault_cnt_d = fault_cnt_q;
    fault_evt   = 1'b0;
    iso_d       = 1'b1;
    por_n_d     = 1'b0;
    pad_oe_en_d = 1'b0;

    case (state_q)
      ST_OFF: begin
        timer_d = '0;
        if (rst_done && enable && sup_ok) begin
          state_d = ST_RAMP;
        end
      end

      ST_RAMP: begin
        if (!sup_ok || !enable) begin
          state_d = ST_OFF;
          timer_d = '0;
        end else if (timer_q == RAMP_LAST) begin
          state_d = ST_HOLD;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      ST_HOLD: begin
        if (!sup_ok) begin
          state_d   = ST_FAULT;
          timer_d   = '0;
          fault_evt = 1'b1;
        end else if (timer_q == HOLD_LAST) begin
          state_d = ST_OEWAIT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      ST_OEWAIT: begin
        timer_d = '0;
        if (!sup_ok) begin
          state_d   = ST_FAULT;
          fault_evt = 1'b1;
        end else begin
          state_d = ST_ON;
        end
      end

      ST_ON: begin
        timer_d = '0;
        // Supply loss outranks a simultaneous shutdown request.
        if (!sup_ok) begin
          state_d   = ST_FAULT;
          fault_evt = 1'b1;
        end else if (!enable) begin
          state_d = ST_OFF;
        end
      end

      ST_FAULT: begin
        timer_d = '0;
        if (!enable) begin
          state_d = ST_OFF;
        end
      end

      default: begin
        state_d = ST_FAULT;
        timer_d = '0;
      end
    endcase

    if (fault_evt && (fault_cnt_q != CNT_MAX)) begin
      fault_cnt_d = fault_cnt_q + CNT_W'(1);
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    case (state_d)
      ST_HOLD: begin
        iso_d = 1'b0;
      end
      ST_OEWAIT: begin
        iso_d   = 1'b0;
        por_n_d = 1'b1;
      end
      ST_ON: begin
        iso_d       = 1'b0;
        por_n_d     = 1'b1;
        pad_oe_en_d = 1'b1;
      end
      default: begin
        iso_d       = 1'b1;
        por_n_d     = 1'b0;
        pad_oe_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      rst_sync_q   <= '0;
      vdd_sync_q   <= '0;
      vddio_sync_q <= '0;
      state_q      <= ST_OFF;
      timer_q      <= '0;
      fault_cnt_q  <= '0;
      iso_q        <= 1'b1;
      por_n_q      <= 1'b0;
      pad_oe_en_q  <= 1'b0;
    end else begin
      rst_sync_q   <= rst_sync_d;
      vdd_sync_q   <= vdd_sync_d;
      vddio_sync_q <= vddio_sync_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      fault_cnt_q  <= fault_cnt_d;
      iso_q        <= iso_d;
      por_n_q      <= por_n_d;
      pad_oe_en_q  <= pad_oe_en_d;
    end
  end

  assign iso       = iso_q;
  assign por_n     = por_n_q;
  assign pad_oe_en = pad_oe_en_q;
  assign state     = state_q;
  assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_io_pad_power_seq.sv
// Bench for io_pad_power_seq: directed vector table, corner sequences, then
// random supply/enable traffic against a cycle-count reference model.
module tb_io_pad_power_seq;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned RAMP_CYCLES = 16;
  localparam int unsigned HOLD_CYCLES = 8;

  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_RAMP  = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_OEW   = 3'd3;
  localparam logic [2:0] S_ON    = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic       ck = 1'b0;
  logic       nrst;
  logic       vdd_ok;
  logic       vddio_ok;
  logic       enable;
  logic       iso;
  logic       por_n;
  logic       pad_oe_en;
  logic [2:0] state;
  logic [3:0] fault_cnt;

  io_pad_power_seq #(
    .SYNC_STAGES(SYNC_STAGES),
    .RAMP_CYCLES(RAMP_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .ck(ck),
    .nrst(nrst),
    .vdd_ok(vdd_ok),
    .vddio_ok(vddio_ok),
    .enable(enable),
    .iso(iso),
    .por_n(por_n),
    .pad_oe_en(pad_oe_en),
    .state(state),
    .fault_cnt(fault_cnt)
  );

  always #5 ck = ~ck;

  int vectors;
  int miscompares;

  typedef struct {
    logic        vdd;
    logic        vddio;
    logic        en;
    int unsigned n;
    logic [2:0]  st;
    logic [3:0]  fc;
  } vec_t;

  vec_t tbl[$];

  // Output table: {iso, por_n, pad_oe_en} for each state.
  function automatic logic [2:0] outs_of(input logic [2:0] st);
    case (st)
      S_HOLD:  return 3'b000;
      S_OEW:   return 3'b010;
      S_ON:    return 3'b011;
      default: return 3'b100;
    endcase
  endfunction

  function automatic vec_t mk(input logic vd, input logic vio, input logic e,
                              input int unsigned n, input logic [2:0] st,
                              input logic [3:0] fc);
    vec_t v;
    v.vdd = vd; v.vddio = vio; v.en = e; v.n = n; v.st = st; v.fc = fc;
    return v;
  endfunction

  task automatic tick();
    @(posedge ck);
    @(negedge ck);
  endtask

  task automatic check(input string name, input logic [2:0] st, input logic [3:0] fc);
    logic [9:0] got;
    logic [9:0] want;
    got  = {state, iso, por_n, pad_oe_en, fault_cnt};
    want = {st, outs_of(st), fc};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got state=%0d iso=%b por_n=%b oe=%b fault_cnt=%0d, want state=%0d iso/por_n/oe=%b fault_cnt=%0d",
               name, state, iso, por_n, pad_oe_en, fault_cnt, st, outs_of(st), fc);
    end
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int lim, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      tick();
      if (state === tgt) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_state: state=%0d, required %0d within %0d cycles", state, tgt, lim);
    end
  endtask

  // Reference model: phases with elapsed-cycle counts, supplies delayed via a queue.
  int m_st;
  int m_el;
  int m_fc;
  int m_redges;
  bit m_sup_q[$];

  task automatic model_reset();
    m_st = S_OFF;
    m_el = 0;
    m_fc = 0;
    m_redges = 0;
    m_sup_q.delete();
    repeat (SYNC_STAGES) m_sup_q.push_back(1'b0);
  endtask

  task automatic model_step(input bit s, input bit e);
    bit sup;
    bit rok;
    bit flt;
    m_sup_q.push_back(s);
    sup = m_sup_q.pop_front();
    rok = (m_redges >= 2);
    if (m_redges < 3) m_redges++;
    flt = 1'b0;
    case (m_st)
      S_OFF:   if (e && sup && rok) begin m_st = S_RAMP; m_el = 1; end
      S_RAMP: begin
        if (!sup || !e) m_st = S_OFF;
        else if (m_el == int'(RAMP_CYCLES)) begin m_st = S_HOLD; m_el = 1; end
        else m_el++;
      end
      S_HOLD: begin
        if (!sup) flt = 1'b1;
        else if (m_el == int'(HOLD_CYCLES)) m_st = S_OEW;
        else m_el++;
      end
      S_OEW:   if (!sup) flt = 1'b1; else m_st = S_ON;
      S_ON:    if (!sup) flt = 1'b1; else if (!e) m_st = S_OFF;
      default: if (!e) m_st = S_OFF;
    endcase
    if (flt) begin
      m_st = S_FAULT;
      m_fc = (m_fc < 15) ? m_fc + 1 : 15;
    end
  endtask

  initial begin
    bit ok;
    vectors = 0;
    miscompares = 0;
    nrst = 1'b0;
    vdd_ok = 1'b1;
    vddio_ok = 1'b1;
    enable = 1'b1;

    // Power-up, supply glitch in RAMP, fault entry/exit, shutdown paths.
    tbl.push_back(mk(1, 1, 1, 2,  S_OFF,   4'd0));
    tbl.push_back(mk(1, 1, 1, 1,  S_RAMP,  4'd0));
    tbl.push_back(mk(1, 1, 1, 15, S_RAMP,  4'd0));
    tbl.push_back(mk(1, 1, 1, 1,  S_HOLD,  4'd0));
    tbl.push_back(mk(1, 1, 1, 7,  S_HOLD,  4'd0));
    tbl.push_back(mk(1, 1, 1, 1,  S_OEW,   4'd0));
    tbl.push_back(mk(1, 1, 1, 1,  S_ON,    4'd0));
    tbl.push_back(mk(1, 1, 1, 5,  S_ON,    4'd0));
    tbl.push_back(mk(1, 1, 0, 1,  S_OFF,   4'd0));
    tbl.push_back(mk(1, 1, 1, 1,  S_RAMP,  4'd0));
    tbl.push_back(mk(1, 1, 1, 10, S_RAMP,  4'd0));
    tbl.push_back(mk(1, 0, 1, 1,  S_RAMP,  4'd0));
    tbl.push_back(mk(1, 0, 1, 1,  S_RAMP,  4'd0));
    tbl.push_back(mk(1, 0, 1, 1,  S_OFF,   4'd0));
    tbl.push_back(mk(1, 1, 1, 1,  S_OFF,   4'd0));
    tbl.push_back(mk(1, 1, 1, 1,  S_OFF,   4'd0));
    tbl.push_back(mk(1, 1, 1, 1,  S_RAMP,  4'd0));
    tbl.push_back(mk(1, 1, 1, 15, S_RAMP,  4'd0));
    tbl.push_back(mk(1, 1, 1, 1,  S_HOLD,  4'd0));
    tbl.push_back(mk(1, 1, 1, 8,  S_OEW,   4'd0));
    tbl.push_back(mk(1, 1, 1, 1,  S_ON,    4'd0));
    tbl.push_back(mk(0, 1, 1, 2,  S_ON,    4'd0));
    tbl.push_back(mk(0, 1, 1, 1,  S_FAULT, 4'd1));
    tbl.push_back(mk(1, 1, 1, 5,  S_FAULT, 4'd1));
    tbl.push_back(mk(1, 1, 0, 1,  S_OFF,   4'd1));
    tbl.push_back(mk(1, 1, 1, 1,  S_RAMP,  4'd1));
    tbl.push_back(mk(1, 1, 1, 16, S_HOLD,  4'd1));
    tbl.push_back(mk(1, 1, 1, 8,  S_OEW,   4'd1));
    tbl.push_back(mk(1, 1, 1, 1,  S_ON,    4'd1));
    tbl.push_back(mk(1, 1, 0, 1,  S_OFF,   4'd1));
    tbl.push_back(mk(1, 1, 1, 1,  S_RAMP,  4'd1));
    tbl.push_back(mk(1, 1, 0, 1,  S_OFF,   4'd1));

    repeat (3) @(posedge ck);
    @(negedge ck);
    check("reset", S_OFF, 4'd0);
    nrst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      vdd_ok   = tbl[i].vdd;
      vddio_ok = tbl[i].vddio;
      enable   = tbl[i].en;
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].fc);
    end

    // Repeated supply loss in HOLD: counter saturates at 15.
    for (int i = 0; i < 16; i++) begin
      enable = 1'b1;
      wait_state(S_HOLD, 60, ok);
      vdd_ok = 1'b0;
      repeat (3) tick();
      check($sformatf("sat%0d", i), S_FAULT, 4'((i + 2 > 15) ? 15 : i + 2));
      vdd_ok = 1'b1;
      enable = 1'b0;
      tick();
    end

    // Asynchronous reset mid-HOLD, observed before any clock edge.
    enable = 1'b1;
    wait_state(S_HOLD, 60, ok);
    repeat (3) tick();
    #2 nrst = 1'b0;
    #1 check("async_rst", S_OFF, 4'd0);
    #1 nrst = 1'b1;
    tick();
    tick();
    check("rst_sync_off", S_OFF, 4'd0);
    tick();
    check("rst_sync_ramp", S_RAMP, 4'd0);

    // Random traffic against the model.
    #2 nrst = 1'b0;
    #1 model_reset();
    check("rnd_reset", 3'(m_st), 4'(m_fc));
    #1 nrst = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 699) == 0) begin
        #2 nrst = 1'b0;
        #1 model_reset();
        check("rnd_async_rst", 3'(m_st), 4'(m_fc));
        #1 nrst = 1'b1;
      end
      vdd_ok   = ($urandom_range(0, 99) >= 1);
      vddio_ok = ($urandom_range(0, 99) >= 1);
      enable   = ($urandom_range(0, 99) >= 3);
      model_step(vdd_ok & vddio_ok, enable);
      tick();
      check($sformatf("rnd%0d", c), 3'(m_st), 4'(m_fc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
